// File: rtl/row_request_arbiter_if.sv
// rtl/row_request_arbiter_if.sv - source/ECD_Master row-request bundle with completion return
interface row_request_arbiter_if #(
    parameter int NUM_SRC         = 4,
    parameter int DATA_W          = 256,
    parameter int MAX_OUTSTANDING = 8
);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [NUM_SRC*DATA_W-1:0] s_tdata;
    logic [NUM_SRC-1:0]        s_tvalid;
    logic [NUM_SRC-1:0]        s_tready;
    logic [NUM_SRC-1:0]        src_enable;
    logic [DATA_W-1:0]         m_tdata;
    logic                      m_tvalid;
    logic                      m_tlast;
    logic                      m_tready;
    logic                      row_complete_in;
    logic [NUM_SRC-1:0]        row_complete_out;
    logic [CNT_W-1:0]          outstanding_out;
    logic                      idle_out;
    logic                      error_out;

    modport master (
        output s_tdata, s_tvalid, src_enable, m_tready, row_complete_in,
        input  s_tready, m_tdata, m_tvalid, m_tlast, row_complete_out,
        input  outstanding_out, idle_out, error_out
    );

    modport slave (
        input  s_tdata, s_tvalid, src_enable, m_tready, row_complete_in,
        output s_tready, m_tdata, m_tvalid, m_tlast, row_complete_out,
        output outstanding_out, idle_out, error_out
    );
endinterface

// File: rtl/row_request_arbiter.sv
// rtl/row_request_arbiter.sv - round-robin row-request arbiter with outstanding cap and completion routing
module row_request_arbiter #(
    parameter int NUM_SRC         = 4,
    parameter int DATA_W          = 256,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                 clk,
    input  logic                 resetn,
    row_request_arbiter_if.slave bus
);
    localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [DATA_W-1:0]  m_tdata_q;
    logic               m_tvalid_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SRC_W-1:0]   owner_mem [MAX_OUTSTANDING];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [NUM_SRC-1:0] rc_out_q, rc_out_d;
    logic               error_q;

    logic [NUM_SRC-1:0] eligible;
    logic [SRC_W-1:0]   grant_idx;
    logic               found;
    logic               can_load;
    logic               grant;
    logic               pop;
    logic               orphan;

    // Rotating priority: first eligible source at or above the pointer, wrapping.
    always_comb begin
        eligible  = bus.s_tvalid & bus.src_enable;
        found     = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (!found && eligible[(int'(rr_ptr_q) + k) % NUM_SRC]) begin
                found     = 1'b1;
                grant_idx = SRC_W'((int'(rr_ptr_q) + k) % NUM_SRC);
            end
        end
    end

    // Credit is taken at grant time; the cap check sees the pre-completion count.
    always_comb begin
        can_load = !m_tvalid_q || bus.m_tready;
        grant    = can_load && (cnt_q < CNT_W'(MAX_OUTSTANDING)) && found;
        pop      = bus.row_complete_in && (cnt_q != '0);
        orphan   = bus.row_complete_in && (cnt_q == '0);
        cnt_d    = cnt_q + CNT_W'(grant) - CNT_W'(pop);
        rc_out_d = pop ? (NUM_SRC'(1) << owner_mem[rd_ptr_q]) : '0;
        rr_ptr_d = rr_ptr_q;
        if (grant) begin
            rr_ptr_d = (grant_idx == SRC_W'(NUM_SRC - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rr_ptr_q   <= '0;
            m_tdata_q  <= '0;
            m_tvalid_q <= 1'b0;
            cnt_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rc_out_q   <= '0;
            error_q    <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            rc_out_q <= rc_out_d;
            if (grant) begin
                m_tdata_q  <= bus.s_tdata[int'(grant_idx)*DATA_W +: DATA_W];
                m_tvalid_q <= 1'b1;
                wr_ptr_q   <= wr_ptr_q + 1'b1;
            end else if (bus.m_tready) begin
                m_tvalid_q <= 1'b0;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (orphan) begin
                error_q <= 1'b1;
            end
        end
    end

    // Owner storage needs no reset: occupancy is defined by the pointers and count.
    always_ff @(posedge clk) begin
        if (resetn && grant) begin
            owner_mem[wr_ptr_q] <= grant_idx;
        end
    end

    assign bus.s_tready         = grant ? (NUM_SRC'(1) << grant_idx) : '0;
    assign bus.m_tdata          = m_tdata_q;
    assign bus.m_tvalid         = m_tvalid_q;
    assign bus.m_tlast          = 1'b1;
    assign bus.row_complete_out = rc_out_q;
    assign bus.outstanding_out  = cnt_q;
    assign bus.idle_out         = (cnt_q == '0) && !m_tvalid_q;
    assign bus.error_out        = error_q;
endmodule

// File: tb/tb_row_request_arbiter.sv
// tb/tb_row_request_arbiter.sv - directed self-checking bench for row_request_arbiter
module tb_row_request_arbiter;
    localparam int NS = 4;
    localparam int DW = 256;
    localparam int MO = 8;

    logic clk;
    logic resetn;

    row_request_arbiter_if #(.NUM_SRC(NS), .DATA_W(DW), .MAX_OUTSTANDING(MO)) bus ();

    row_request_arbiter #(.NUM_SRC(NS), .DATA_W(DW), .MAX_OUTSTANDING(MO)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    string       phase  = "init";
    int          cyc_n  = 0;
    int          nreq [NS];
    int          owners [$];
    int          cnt;
    logic        exp_mvalid;
    logic [DW-1:0] exp_mdata;
    logic        exp_err;

    function automatic logic [DW-1:0] dval(input int s, input int n);
        return {32'(s + 1), 32'hC0DE_0000 ^ 32'(n * 7), 192'(n)};
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s/%s/c%0d observed=%0h expected=%0h", phase, tag, cyc_n, obs, expv);
        end
    endtask

    task automatic load_src(input int s);
        bus.s_tdata[s*DW +: DW] = dval(s, nreq[s]);
    endtask

    task automatic check_outputs(input logic [NS-1:0] exp_rco);
        chk("m_tvalid", DW'(bus.m_tvalid), DW'(exp_mvalid));
        if (exp_mvalid) chk("m_tdata", bus.m_tdata, exp_mdata);
        chk("m_tlast", DW'(bus.m_tlast), DW'(1'b1));
        chk("outstanding", DW'(bus.outstanding_out), DW'(cnt));
        chk("row_complete_out", DW'(bus.row_complete_out), DW'(exp_rco));
        chk("idle", DW'(bus.idle_out), DW'((cnt == 0) && !exp_mvalid));
        chk("error", DW'(bus.error_out), DW'(exp_err));
    endtask

    // One clock: g is the hand-computed granted source (-1 = none), rc drives row_complete_in.
    task automatic cyc(input int g, input logic rc);
        logic [NS-1:0] exp_rco;
        logic          pop;
        bus.row_complete_in = rc;
        #1;
        chk("s_tready", DW'(bus.s_tready), (g < 0) ? '0 : DW'(NS'(1) << g));
        pop     = rc && (cnt > 0);
        exp_rco = '0;
        if (rc && cnt == 0) exp_err = 1'b1;
        if (pop) exp_rco = NS'(1) << owners.pop_front();
        if (g >= 0) begin
            owners.push_back(g);
            exp_mdata  = dval(g, nreq[g]);
            exp_mvalid = 1'b1;
        end else if (bus.m_tready) begin
            exp_mvalid = 1'b0;
        end
        cnt = cnt + ((g >= 0) ? 1 : 0) - (pop ? 1 : 0);
        @(posedge clk);
        #1;
        cyc_n++;
        check_outputs(exp_rco);
        bus.row_complete_in = 1'b0;
        if (g >= 0) begin
            nreq[g]++;
            load_src(g);
        end
    endtask

    task automatic do_reset();
        bus.s_tvalid        = '0;
        bus.row_complete_in = 1'b0;
        resetn              = 1'b0;
        @(posedge clk);
        #1;
        cnt        = 0;
        owners     = {};
        exp_mvalid = 1'b0;
        exp_mdata  = '0;
        exp_err    = 1'b0;
        chk("rst_m_tdata", bus.m_tdata, '0);
        chk("rst_s_tready", DW'(bus.s_tready), '0);
        check_outputs('0);
        resetn = 1'b1;
    endtask

    initial begin
        resetn              = 1'b0;
        bus.s_tdata         = '0;
        bus.s_tvalid        = '0;
        bus.src_enable      = '1;
        bus.m_tready        = 1'b1;
        bus.row_complete_in = 1'b0;
        for (int s = 0; s < NS; s++) begin
            nreq[s] = 0;
            load_src(s);
        end
        repeat (2) @(posedge clk);
        #1;
        phase = "reset";
        do_reset();

        phase = "cap";
        bus.s_tvalid = 4'b0001;
        for (int k = 0; k < 8; k++) cyc(0, 1'b0);
        cyc(-1, 1'b0);
        cyc(-1, 1'b0);
        cyc(-1, 1'b1);
        cyc(0, 1'b0);
        cyc(-1, 1'b0);

        phase = "rr";
        do_reset();
        bus.s_tvalid = 4'b1111;
        cyc(0, 1'b0);
        cyc(1, 1'b1); cyc(2, 1'b1); cyc(3, 1'b1);
        cyc(0, 1'b1); cyc(1, 1'b1); cyc(2, 1'b1); cyc(3, 1'b1);
        bus.src_enable = 4'b1011;
        cyc(0, 1'b1); cyc(1, 1'b1); cyc(3, 1'b1);
        cyc(0, 1'b1); cyc(1, 1'b1); cyc(3, 1'b1);
        bus.s_tvalid   = '0;
        bus.src_enable = '1;
        cyc(-1, 1'b1);

        phase = "route";
        do_reset();
        bus.s_tvalid = 4'b0100; cyc(2, 1'b0);
        bus.s_tvalid = 4'b0001; cyc(0, 1'b0);
        bus.s_tvalid = 4'b1000; cyc(3, 1'b0);
        bus.s_tvalid = 4'b0000;
        cyc(-1, 1'b1); cyc(-1, 1'b1); cyc(-1, 1'b1);

        phase = "bp";
        bus.s_tvalid = 4'b0010;
        bus.m_tready = 1'b0;
        cyc(1, 1'b0);
        for (int k = 0; k < 5; k++) cyc(-1, 1'b0);
        bus.m_tready = 1'b1;
        cyc(1, 1'b0);
        bus.s_tvalid = '0;
        cyc(-1, 1'b0);

        phase = "orphan";
        do_reset();
        cyc(-1, 1'b1);
        bus.s_tvalid = 4'b0001; cyc(0, 1'b0);
        bus.s_tvalid = 4'b0000; cyc(-1, 1'b1);
        cyc(-1, 1'b0);
        do_reset();

        phase = "full";
        bus.s_tvalid = 4'b1111;
        cyc(0, 1'b0); cyc(1, 1'b0); cyc(2, 1'b0); cyc(3, 1'b0);
        cyc(0, 1'b0); cyc(1, 1'b0); cyc(2, 1'b0); cyc(3, 1'b0);
        cyc(-1, 1'b1);
        cyc(0, 1'b0);

        phase = "midrst";
        do_reset();
        bus.s_tvalid = 4'b1111;
        cyc(0, 1'b0); cyc(1, 1'b0); cyc(2, 1'b0); cyc(3, 1'b0); cyc(0, 1'b0);
        do_reset();
        cyc(-1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/row_request_arbiter.md
Name: row_request_arbiter

Overview:
Shares the single AXI-Stream row-request channel to ECD_Master among NUM_SRC independent row-request generators. Arbitrates round-robin and enforces a global cap of MAX_OUTSTANDING unfulfilled row requests. Records which source issued each request and routes each row-complete pulse from ECD_Master back to that source, in issue order. Sits between the request generators and the ECD_Master request port.

Parameters:
NUM_SRC, 4, number of requesting sources (2..8)
DATA_W, 256, request beat width in bits
MAX_OUTSTANDING, 8, global cap on granted-but-uncompleted requests (power of 2, 2..16)

Ports:
clk  input  1  clock
resetn  input  1  synchronous, active-low reset
s_tdata  input  NUM_SRC*DATA_W  source request beats; source i occupies bits [i*DATA_W +: DATA_W]
s_tvalid  input  NUM_SRC  per-source request valid
s_tready  output  NUM_SRC  per-source accept; one-hot or zero
src_enable  input  NUM_SRC  1 = source eligible for new grants
m_tdata  output  DATA_W  request beat to ECD_Master
m_tvalid  output  1  request valid
m_tlast  output  1  always 1; each request is a single beat
m_tready  input  1  ECD_Master accept
row_complete_in  input  1  one-cycle pulse per fulfilled row from ECD_Master
row_complete_out  output  NUM_SRC  one-cycle pulse to the source that owns the completed row
outstanding_out  output  clog2(MAX_OUTSTANDING+1)  current outstanding count
idle_out  output  1  high when outstanding_out==0 and m_tvalid==0
error_out  output  1  sticky; row_complete_in arrived with no outstanding request

Behaviour:
- Reset (resetn==0 at a clk edge): all outputs go to 0, except m_tlast (constant 1) and idle_out (1). Round-robin pointer is set to 0, owner FIFO is emptied, outstanding count is 0, error_out is cleared. Applies mid-operation: any in-flight beat and all pending completions are discarded.
- m_tdata/m_tvalid form an output register. The register can load when (!m_tvalid || m_tready).
- A grant occurs in a cycle when all of the following hold:
  - the output register can load;
  - outstanding count < MAX_OUTSTANDING;
  - at least one i has s_tvalid[i] && src_enable[i].
- Grant selection: the first eligible source searching upward from the pointer, wrapping modulo NUM_SRC.
- On a grant to source g:
  - s_tready[g]=1, combinational, same cycle;
  - m_tdata <= s_tdata[g] and m_tvalid <= 1 at the next edge, so latency is 1 cycle from grant to m_tvalid;
  - g is pushed into the owner FIFO;
  - the outstanding count increments;
  - pointer <= (g+1) mod NUM_SRC.
- If m_tvalid && m_tready and no grant occurs: m_tvalid <= 0.
- Under backpressure (m_tvalid && !m_tready), m_tdata holds stable and no grant occurs.
- s_tready is never asserted to a source with src_enable==0 or s_tvalid==0.
- Credit is consumed at grant, not at m_tready. A beat held in the output register counts as outstanding.
- Owner FIFO: depth MAX_OUTSTANDING, entries clog2(NUM_SRC) bits wide. It cannot overflow because of the credit cap.
- Completion with a non-empty FIFO: the head h is popped, row_complete_out[h] pulses at the next edge (1-cycle latency), and the outstanding count decrements.
- Completion with an empty FIFO: the pulse is ignored, no row_complete_out pulse is produced, and error_out <= 1 (sticky until reset).
- Grant and completion in the same cycle: push and pop both occur (pop reads the pre-push head), and the outstanding count is unchanged. This is legal at outstanding==MAX_OUTSTANDING: the grant is still blocked that cycle, because the cap check uses the current count.
- Deasserting src_enable mid-operation: blocks new grants only. Completions for that source's earlier requests are still routed to it.
- Pointer wrap: after a grant to NUM_SRC-1, the pointer becomes 0.

Test Plan:
- Source 0 only, 10 valid requests, m_tready=1, no completions -> exactly 8 grants with m_tdata matching in order; outstanding_out==8; s_tready[0] stays 0 afterwards; one row_complete_in -> row_complete_out[0] pulses one cycle later and exactly one more grant follows.
- All 4 sources continuously valid and enabled, m_tready=1, completions fed back 1 cycle after each m_tvalid -> grant sequence 0,1,2,3,0,1,... with no skipped source; src_enable[2]=0 mid-run -> sequence 0,1,3,0,1,3.
- Grants to sources 2, 0, 3 in that order, then three row_complete_in pulses -> row_complete_out pulses on bits 2, 0, 3 in order; outstanding_out goes 3,2,1,0; idle_out=1 at the end.
- m_tready=0 for 5 cycles with a beat held -> m_tvalid=1 and m_tdata unchanged throughout, all s_tready=0; m_tready=1 -> beat accepted, next grant loads in the same cycle.
- row_complete_in with nothing outstanding -> no row_complete_out pulse, error_out=1 and it stays 1 through later traffic; resetn=0 -> error_out=0.
- Outstanding at 8 with a simultaneous grant request and completion -> no grant that cycle, count goes to 7, grant occurs the next cycle; resetn=0 mid-flight with 5 outstanding -> m_tvalid=0, outstanding_out=0, and a later completion sets error_out.
